system_0_keys_in: RTL and testbench
===================================

# system_0_keys_in

Avalon-MM slave input port for the board pushbuttons: synchronises, debounces and edge-detects a parallel input bus and presents it to the Nios II as a readable data register, a per-bit edge-capture register and a masked level interrupt. It is the input-side counterpart of the LED output port: same s1 register window, same zero-wait-state read path, sitting between the board pins and the system interconnect.

## Interface
- WIDTH, 4: number of input bits (1..32).
- DEBOUNCE, 16: consecutive stable cycles required before a bit change is accepted (1..65535).
- EDGE_TYPE, 1: capture condition per bit; 0 rising, 1 falling, 2 any.

- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset; all state clears immediately on assertion.
- address  in  2  word offset within s1.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data; bits above WIDTH-1 ignored.
- in_port  in  WIDTH  asynchronous board inputs.
- readdata  out  32  read data, combinational, zero-extended.
- irq  out  1  level interrupt, high while any unmasked captured edge is pending.

## Operation
- Register map (word offsets): 0 data (RO, debounced value); 1 reserved (reads 0, writes ignored); 2 irqmask (RW); 3 edgecapture (R, write-1-to-clear per bit).
- Input path per bit: two-flop synchroniser (s1, s2), then debouncer holding deb and counter cnt (width clog2(DEBOUNCE)).
- Debouncer: s2 == deb -> cnt <= 0. s2 != deb and cnt == DEBOUNCE-1 -> deb <= s2, cnt <= 0, raise one-cycle change pulse. Otherwise cnt <= cnt+1. Any return of s2 to deb before terminal count discards the partial count.
- Edge detect: change pulse qualified by direction (new deb 1 = rising, 0 = falling) and EDGE_TYPE sets edgecapture[i].
- Clear: write to offset 3 with writedata[i]=1 clears edgecapture[i]; 0 bits untouched. Same-cycle set and clear on one bit: set wins.
- irqmask: write to offset 2 loads writedata[WIDTH-1:0].
- irq = |(edgecapture & irqmask), combinational from registers, no extra flop.
- readdata = selected register zero-extended to 32; unselected/reserved offset returns 0. Read has no side effects.
- Writes require chipselect=1 and write_n=0; offsets 0 and 1 writes are no-ops.

## Timing
- Reset values: s1, s2, deb, cnt, irqmask, edgecapture all 0; readdata 0; irq 0.
- Deb reset value 0: an input held high through reset is accepted as a rising edge DEBOUNCE+2 cycles after reset release (captured only if EDGE_TYPE is 0 or 2).
- in_port stable from before edge k: s2 updates at edge k+1, deb and edgecapture at edge k+1+DEBOUNCE, irq high immediately after that edge if masked in.
- Glitch shorter than DEBOUNCE cycles at s2: no change to deb, no capture.
- Write-1-to-clear at edge n: edgecapture bit and irq low after edge n (if no new edge that cycle).
- readdata valid same cycle as address/chipselect (read latency 0, no wait states).
- Reset mid-count: counter and captured state lost; no pulse generated.

## Structure
- Package system_0_keys_pkg: register offset constants (DATA=0, IRQMASK=2, EDGECAP=3), EDGE_TYPE encodings (RISING=0, FALLING=1, ANY=2).
- Sub-module system_0_keys_debounce: one bit of synchroniser + debouncer + change pulse/direction output, parameterised by DEBOUNCE; top level instantiates WIDTH copies via generate and owns the register file and read mux.

## Test plan
- Reset with in_port=4'hF, EDGE_TYPE=1, DEBOUNCE=4: readdata at offset 0 becomes 0x0000000F exactly 6 cycles after reset release; offset 3 reads 0; irq stays 0.
- Press bit 2 (in_port 4'hF -> 4'hB) held, irqmask=4'h4: edgecapture=0x4 and irq=1 after DEBOUNCE+2 edges; write 0x4 to offset 3 -> edgecapture 0, irq 0 next cycle.
- 3-cycle low glitch on bit 0 with DEBOUNCE=4: data stays 0xF, edgecapture stays 0.
- Falling edge on bit 1 with irqmask=0: edgecapture=0x2, irq=0; then write irqmask=0x2 -> irq=1 same cycle after write edge.
- Clear write to bit 3 in the same cycle its debounced falling edge lands: edgecapture[3]=1 afterwards (set wins).
- EDGE_TYPE=2, press then release bit 0: both edges captured, each cleared individually; offset 1 reads 0 and writes to offsets 0/1 leave all state unchanged.

Source files
------------

// File: rtl/system_0_keys_pkg.sv
// Shared constants for the pushbutton input port: s1 register offsets and edge-capture modes.
package system_0_keys_pkg;

    localparam logic [1:0] DATA    = 2'd0;
    localparam logic [1:0] IRQMASK = 2'd2;
    localparam logic [1:0] EDGECAP = 2'd3;

    localparam int unsigned RISING  = 0;
    localparam int unsigned FALLING = 1;
    localparam int unsigned ANY     = 2;

endpackage

// File: rtl/system_0_keys_debounce.sv
// One input bit: two-flop synchroniser followed by a stable-count debouncer.
// Emits a one-cycle change pulse and the new level when a change is accepted.
module system_0_keys_debounce #(
    parameter int unsigned DEBOUNCE = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic change,
    output logic rise
);

    localparam int unsigned CntW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    logic            s1_q, s2_q;
    logic            deb_q, deb_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            deb_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= din;
            s2_q  <= s1_q;
            deb_q <= deb_d;
            cnt_q <= cnt_d;
        end
    end

    // Any return of s2 to the accepted level discards the partial count.
    always_comb begin
        deb_d  = deb_q;
        cnt_d  = cnt_q;
        change = 1'b0;
        if (s2_q == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntW'(DEBOUNCE - 1)) begin
            deb_d  = s2_q;
            cnt_d  = '0;
            change = 1'b1;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    assign level = deb_q;
    assign rise  = s2_q;

endmodule

// File: rtl/system_0_keys_in.sv
// Avalon-MM s1 input port for the board pushbuttons: debounced data register,
// per-bit edge capture with write-1-to-clear, and a masked level interrupt.
module system_0_keys_in
    import system_0_keys_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned DEBOUNCE  = 16,
    parameter int unsigned EDGE_TYPE = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] deb, change, rise, hit;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic             wr;
    logic             unused_writedata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        system_0_keys_debounce #(
            .DEBOUNCE (DEBOUNCE)
        ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .din     (in_port[i]),
            .level   (deb[i]),
            .change  (change[i]),
            .rise    (rise[i])
        );

        assign hit[i] = change[i] &
                        ((EDGE_TYPE == ANY) ||
                         ((EDGE_TYPE == RISING)  &&  rise[i]) ||
                         ((EDGE_TYPE == FALLING) && !rise[i]));
    end

    assign wr               = chipselect && !write_n;
    assign unused_writedata = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask_q <= '0;
            edgecap_q <= '0;
        end else begin
            irqmask_q <= irqmask_d;
            edgecap_q <= edgecap_d;
        end
    end

    // A new edge landing in the same cycle as its clear keeps the bit set.
    always_comb begin
        irqmask_d = irqmask_q;
        edgecap_d = edgecap_q;
        if (wr && address == IRQMASK) begin
            irqmask_d = writedata[WIDTH-1:0];
        end
        if (wr && address == EDGECAP) begin
            edgecap_d = edgecap_d & ~writedata[WIDTH-1:0];
        end
        edgecap_d = edgecap_d | hit;
    end

    assign irq = |(edgecap_q & irqmask_q);

    always_comb begin
        readdata = '0;
        if (chipselect) begin
            case (address)
                DATA:    readdata[WIDTH-1:0] = deb;
                IRQMASK: readdata[WIDTH-1:0] = irqmask_q;
                EDGECAP: readdata[WIDTH-1:0] = edgecap_q;
                default: readdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_system_0_keys_in.sv
// Directed bench for the pushbutton input port: a falling-edge instance and an any-edge instance.
module tb_system_0_keys_in;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        cs_a, cs_b;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_a, in_b;
    logic [31:0] rd_a, rd_b;
    logic        irq_a, irq_b;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] rd;

    always #5 clk = ~clk;

    system_0_keys_in #(.WIDTH(4), .DEBOUNCE(4), .EDGE_TYPE(1)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (cs_a),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_a),
        .readdata   (rd_a),
        .irq        (irq_a)
    );

    system_0_keys_in #(.WIDTH(4), .DEBOUNCE(4), .EDGE_TYPE(2)) dut_any (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (cs_b),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_b),
        .readdata   (rd_b),
        .irq        (irq_b)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_reg(input bit which, input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write_n   = 1'b0;
        if (which) cs_b = 1'b1;
        else       cs_a = 1'b1;
        @(posedge clk);
        #1;
        write_n = 1'b1;
        cs_a    = 1'b0;
        cs_b    = 1'b0;
    endtask

    task automatic read_reg(input bit which, input logic [1:0] a, output logic [31:0] d);
        address = a;
        write_n = 1'b1;
        if (which) cs_b = 1'b1;
        else       cs_a = 1'b1;
        #1;
        d    = which ? rd_b : rd_a;
        cs_a = 1'b0;
        cs_b = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        in_a    = 4'hF;
        in_b    = 4'h0;
        tick(3);
        read_reg(0, 2'd0, rd);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want %h", rd, 32'h0); end
        @(posedge clk);
        #1 reset_n = 1'b1;
        tick(5);
        read_reg(0, 2'd0, rd);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL data_before_accept: got %h want %h", rd, 32'h0); end
        tick(1);
        read_reg(0, 2'd0, rd);
        n_checks++;
        if (rd !== 32'hF) begin n_fail++; $display("FAIL data_accept_6: got %h want %h", rd, 32'hF); end
        read_reg(0, 2'd3, rd);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_rise_not_captured: got %h want %h", rd, 32'h0); end
        n_checks++;
        if (irq_a !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq_a); end
    endtask

    task automatic test_press;
        write_reg(0, 2'd2, 32'h4);
        in_a = 4'hB;
        tick(5);
        read_reg(0, 2'd3, rd);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL press_early: got %h want %h", rd, 32'h0); end
        tick(1);
        read_reg(0, 2'd3, rd);
        n_checks++;
        if (rd !== 32'h4) begin n_fail++; $display("FAIL press_capture: got %h want %h", rd, 32'h4); end
        n_checks++;
        if (irq_a !== 1'b1) begin n_fail++; $display("FAIL press_irq: got %b want 1", irq_a); end
        read_reg(0, 2'd0, rd);
        n_checks++;
        if (rd !== 32'hB) begin n_fail++; $display("FAIL press_data: got %h want %h", rd, 32'hB); end
        write_reg(0, 2'd3, 32'h4);
        read_reg(0, 2'd3, rd);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL press_clear: got %h want %h", rd, 32'h0); end
        n_checks++;
        if (irq_a !== 1'b0) begin n_fail++; $display("FAIL press_clear_irq: got %b want 0", irq_a); end
    endtask

    task automatic test_glitch;
        in_a = 4'hA;
        tick(3);
        in_a = 4'hB;
        tick(10);
        read_reg(0, 2'd0, rd);
        n_checks++;
        if (rd !== 32'hB) begin n_fail++; $display("FAIL glitch_data: got %h want %h", rd, 32'hB); end
        read_reg(0, 2'd3, rd);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL glitch_edgecap: got %h want %h", rd, 32'h0); end
    endtask

    task automatic test_mask;
        write_reg(0, 2'd2, 32'h0);
        in_a = 4'h9;
        tick(6);
        read_reg(0, 2'd3, rd);
        n_checks++;
        if (rd !== 32'h2) begin n_fail++; $display("FAIL mask_capture: got %h want %h", rd, 32'h2); end
        n_checks++;
        if (irq_a !== 1'b0) begin n_fail++; $display("FAIL mask_irq_off: got %b want 0", irq_a); end
        write_reg(0, 2'd2, 32'hFFFF_FFF2);
        n_checks++;
        if (irq_a !== 1'b1) begin n_fail++; $display("FAIL mask_irq_on: got %b want 1", irq_a); end
        read_reg(0, 2'd2, rd);
        n_checks++;
        if (rd !== 32'h2) begin n_fail++; $display("FAIL mask_readback: got %h want %h", rd, 32'h2); end
        write_reg(0, 2'd3, 32'h2);
        n_checks++;
        if (irq_a !== 1'b0) begin n_fail++; $display("FAIL mask_clear_irq: got %b want 0", irq_a); end
    endtask

    task automatic test_set_wins;
        in_a = 4'h1;
        tick(5);
        write_reg(0, 2'd3, 32'h8);
        read_reg(0, 2'd3, rd);
        n_checks++;
        if (rd !== 32'h8) begin n_fail++; $display("FAIL set_wins: got %h want %h", rd, 32'h8); end
        write_reg(0, 2'd3, 32'h8);
        read_reg(0, 2'd3, rd);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL set_wins_clear: got %h want %h", rd, 32'h0); end
    endtask

    task automatic test_any_edge;
        in_b = 4'h1;
        tick(6);
        read_reg(1, 2'd3, rd);
        n_checks++;
        if (rd !== 32'h1) begin n_fail++; $display("FAIL any_rise: got %h want %h", rd, 32'h1); end
        write_reg(1, 2'd3, 32'h1);
        read_reg(1, 2'd3, rd);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL any_rise_clear: got %h want %h", rd, 32'h0); end
        in_b = 4'h0;
        tick(6);
        read_reg(1, 2'd3, rd);
        n_checks++;
        if (rd !== 32'h1) begin n_fail++; $display("FAIL any_fall: got %h want %h", rd, 32'h1); end
        read_reg(1, 2'd1, rd);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL reserved_read: got %h want %h", rd, 32'h0); end
        write_reg(1, 2'd0, 32'hF);
        write_reg(1, 2'd1, 32'hF);
        read_reg(1, 2'd0, rd);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL ro_data: got %h want %h", rd, 32'h0); end
        read_reg(1, 2'd3, rd);
        n_checks++;
        if (rd !== 32'h1) begin n_fail++; $display("FAIL ro_edgecap: got %h want %h", rd, 32'h1); end
        read_reg(1, 2'd2, rd);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL ro_irqmask: got %h want %h", rd, 32'h0); end
        n_checks++;
        if (irq_b !== 1'b0) begin n_fail++; $display("FAIL any_irq_masked: got %b want 0", irq_b); end
        write_reg(1, 2'd2, 32'h1);
        n_checks++;
        if (irq_b !== 1'b1) begin n_fail++; $display("FAIL any_irq_on: got %b want 1", irq_b); end
        write_reg(1, 2'd3, 32'h1);
        n_checks++;
        if (irq_b !== 1'b0) begin n_fail++; $display("FAIL any_irq_clear: got %b want 0", irq_b); end
        address = 2'd0;
        #1;
        n_checks++;
        if (rd_b !== 32'h0) begin n_fail++; $display("FAIL unselected_read: got %h want %h", rd_b, 32'h0); end
    endtask

    task automatic test_reset_mid_count;
        write_reg(0, 2'd2, 32'h1);
        in_a = 4'h0;
        tick(3);
        reset_n = 1'b0;
        #1;
        read_reg(0, 2'd0, rd);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL async_reset_data: got %h want %h", rd, 32'h0); end
        tick(2);
        reset_n = 1'b1;
        tick(8);
        read_reg(0, 2'd3, rd);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL midcount_edgecap: got %h want %h", rd, 32'h0); end
        read_reg(0, 2'd2, rd);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL midcount_irqmask: got %h want %h", rd, 32'h0); end
        n_checks++;
        if (irq_a !== 1'b0) begin n_fail++; $display("FAIL midcount_irq: got %b want 0", irq_a); end
    endtask

    initial begin
        address   = 2'd0;
        cs_a      = 1'b0;
        cs_b      = 1'b0;
        write_n   = 1'b1;
        writedata = 32'h0;
        test_reset();
        test_press();
        test_glitch();
        test_mask();
        test_set_wins();
        test_any_edge();
        test_reset_mid_count();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
